// File: rtl/mapper_pkg.sv
// Shared constants and types for the banked 4510-style address mapper.
// Opcodes, MAP sequencer states and hypervisor register select codes.
package mapper_pkg;

  localparam logic [7:0] MAP_OPC = 8'h5C;
  localparam logic [7:0] EOM_OPC = 8'hEA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LD_A,
    ST_LD_X,
    ST_LD_Y,
    ST_LD_Z
  } map_state_e;

  localparam logic [2:0] SEL_Z     = 3'd0;
  localparam logic [2:0] SEL_Y     = 3'd1;
  localparam logic [2:0] SEL_X     = 3'd2;
  localparam logic [2:0] SEL_A     = 3'd3;
  localparam logic [2:0] SEL_MB_LO = 3'd4;
  localparam logic [2:0] SEL_MB_HI = 3'd5;

endpackage

// File: rtl/mapper_set_regs.sv
// One map register set: offset, region enables and MB bits for both halves.
// A single write port is shared by the MAP sequencer and the hypervisor.
module mapper_set_regs
  import mapper_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [2:0]  sel,
  input  logic [7:0]  wdata,
  input  logic [2:0]  rd_sel,
  output logic [7:0]  rdata,
  output logic [19:0] off_lo,
  output logic [19:0] off_hi,
  output logic [3:0]  en_lo,
  output logic [3:0]  en_hi
);

  logic [1:0][7:0] lo8_q, lo8_d;
  logic [1:0][3:0] hi4_q, hi4_d;
  logic [1:0][3:0] en_q, en_d;
  logic [1:0][7:0] mb_q, mb_d;

  always_comb begin
    lo8_d = lo8_q;
    hi4_d = hi4_q;
    en_d  = en_q;
    mb_d  = mb_q;
    if (we) begin
      case (sel)
        SEL_A: lo8_d[0] = wdata;
        SEL_X: begin
          en_d[0]  = wdata[7:4];
          hi4_d[0] = wdata[3:0];
        end
        SEL_Y: lo8_d[1] = wdata;
        SEL_Z: begin
          en_d[1]  = wdata[7:4];
          hi4_d[1] = wdata[3:0];
        end
        SEL_MB_LO: mb_d[0] = wdata;
        SEL_MB_HI: mb_d[1] = wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (rd_sel)
      SEL_Z:     rdata = {en_q[1], hi4_q[1]};
      SEL_Y:     rdata = lo8_q[1];
      SEL_X:     rdata = {en_q[0], hi4_q[0]};
      SEL_A:     rdata = lo8_q[0];
      SEL_MB_LO: rdata = mb_q[0];
      SEL_MB_HI: rdata = mb_q[1];
      default:   rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lo8_q <= '0;
      hi4_q <= '0;
      en_q  <= '0;
      mb_q  <= '0;
    end else begin
      lo8_q <= lo8_d;
      hi4_q <= hi4_d;
      en_q  <= en_d;
      mb_q  <= mb_d;
    end
  end

  assign off_lo = {mb_q[0], hi4_q[0], lo8_q[0]};
  assign off_hi = {mb_q[1], hi4_q[1], lo8_q[1]};
  assign en_lo  = en_q[0];
  assign en_hi  = en_q[1];

endmodule

// File: rtl/mapper_banked.sv
// Banked MAP unit: translates core addresses through selectable map sets,
// sequences the MAP/EOM opcodes itself and masks interrupts while mapping.
module mapper_banked
  import mapper_pkg::*;
#(
  parameter int PADDR_W  = 20,
  parameter int NUM_SETS = 2,
  parameter int SET_W    = $clog2(NUM_SETS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ready,
  input  logic               sync,
  input  logic [7:0]         data_i,
  input  logic [7:0]         data_o,
  input  logic [15:0]        core_address_next,
  input  logic [SET_W-1:0]   active_set,
  input  logic [SET_W-1:0]   load_set,
  input  logic               ext_irq,
  input  logic               ext_nmi,
  output logic               cpu_irq,
  output logic               cpu_nmi,
  input  logic               hv_we,
  input  logic [SET_W-1:0]   hv_set,
  input  logic [2:0]         hv_sel,
  input  logic [7:0]         hv_wdata,
  output logic [7:0]         hv_rdata,
  output logic               map_busy,
  output logic [PADDR_W-1:0] address,
  output logic [PADDR_W-1:0] address_next,
  output logic               map,
  output logic               map_next
);

  map_state_e         state_q, state_d;
  logic               int_en_q, int_en_d;
  logic               nmi_pend_q, nmi_pend_d;
  logic               nmi_prev_q, nmi_prev_d;
  logic [PADDR_W-1:0] addr_q, addr_d;
  logic               map_q, map_d;

  logic       map_det, eom_det;
  logic       core_we, hv_ok;
  logic [2:0] core_sel;

  logic [19:0] off_lo_s [NUM_SETS];
  logic [19:0] off_hi_s [NUM_SETS];
  logic [3:0]  en_lo_s  [NUM_SETS];
  logic [3:0]  en_hi_s  [NUM_SETS];
  logic [7:0]  rdata_s  [NUM_SETS];

  assign map_det  = ready & sync & (data_i == MAP_OPC);
  assign eom_det  = ready & sync & (data_i == EOM_OPC);
  assign map_busy = (state_q != ST_IDLE) | map_det;
  assign hv_ok    = hv_we & ready & ~map_busy;

  always_comb begin
    state_d  = state_q;
    core_we  = 1'b0;
    core_sel = SEL_A;
    if (ready) begin
      unique case (state_q)
        ST_IDLE: if (map_det) state_d = ST_LD_A;
        ST_LD_A: begin
          core_we  = 1'b1;
          core_sel = SEL_A;
          state_d  = ST_LD_X;
        end
        ST_LD_X: begin
          core_we  = 1'b1;
          core_sel = SEL_X;
          state_d  = ST_LD_Y;
        end
        ST_LD_Y: begin
          core_we  = 1'b1;
          core_sel = SEL_Y;
          state_d  = ST_LD_Z;
        end
        ST_LD_Z: begin
          core_we  = 1'b1;
          core_sel = SEL_Z;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
    logic we_s;
    assign we_s = (core_we & (load_set == SET_W'(s)))
                | (hv_ok & (hv_set == SET_W'(s)));
    mapper_set_regs u_regs (
      .clk    (clk),
      .reset  (reset),
      .we     (we_s),
      .sel    (core_we ? core_sel : hv_sel),
      .wdata  (core_we ? data_o : hv_wdata),
      .rd_sel (hv_sel),
      .rdata  (rdata_s[s]),
      .off_lo (off_lo_s[s]),
      .off_hi (off_hi_s[s]),
      .en_lo  (en_lo_s[s]),
      .en_hi  (en_hi_s[s])
    );
  end

  assign hv_rdata = rdata_s[hv_set];

  logic               half;
  logic [1:0]         region;
  logic [19:0]        off;
  logic [3:0]         en;
  logic [27:0]        base;
  logic               hit;
  logic [PADDR_W-1:0] phys;

  assign half   = core_address_next[15];
  assign region = core_address_next[14:13];
  assign off    = half ? off_hi_s[active_set] : off_lo_s[active_set];
  assign en     = half ? en_hi_s[active_set] : en_lo_s[active_set];
  assign base   = {off, 8'h00};
  assign hit    = en[region];
  // Carry out of bit 19 runs into the MB bits and wraps at the top.
  assign phys   = hit ? PADDR_W'(base) + PADDR_W'(core_address_next)
                      : PADDR_W'(core_address_next);

  always_comb begin
    int_en_d   = int_en_q;
    nmi_pend_d = nmi_pend_q;
    nmi_prev_d = nmi_prev_q;
    addr_d     = addr_q;
    map_d      = map_q;
    if (ready) begin
      addr_d     = phys;
      map_d      = hit;
      nmi_prev_d = ext_nmi;
      if (eom_det) int_en_d = 1'b1;
      if (state_q == ST_LD_A) int_en_d = 1'b0;
      if (int_en_q) nmi_pend_d = 1'b0;
      else if (ext_nmi & ~nmi_prev_q) nmi_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      int_en_q   <= 1'b1;
      nmi_pend_q <= 1'b0;
      nmi_prev_q <= 1'b0;
      addr_q     <= '0;
      map_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      int_en_q   <= int_en_d;
      nmi_pend_q <= nmi_pend_d;
      nmi_prev_q <= nmi_prev_d;
      addr_q     <= addr_d;
      map_q      <= map_d;
    end
  end

  assign address_next = addr_d;
  assign map_next     = map_d;
  assign address      = addr_q;
  assign map          = map_q;
  assign cpu_irq      = ext_irq & int_en_q;
  assign cpu_nmi      = int_en_q & (ext_nmi | nmi_pend_q);

endmodule

// File: tb/tb_mapper_banked.sv
// Bench for mapper_banked: directed MAP/EOM/NMI/hypervisor scenarios then
// random traffic, all checked against a register-level reference model.
module tb_mapper_banked;

  localparam int PW = 28;
  localparam longint PMASK = (64'd1 << PW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ready = 1'b1;
  logic          sync = 1'b0;
  logic [7:0]    data_i = 8'h00;
  logic [7:0]    data_o = 8'h00;
  logic [15:0]   core_address_next = 16'h0000;
  logic [0:0]    active_set = 1'b0;
  logic [0:0]    load_set = 1'b0;
  logic          ext_irq = 1'b0;
  logic          ext_nmi = 1'b0;
  logic          cpu_irq, cpu_nmi;
  logic          hv_we = 1'b0;
  logic [0:0]    hv_set = 1'b0;
  logic [2:0]    hv_sel = 3'd0;
  logic [7:0]    hv_wdata = 8'h00;
  logic [7:0]    hv_rdata;
  logic          map_busy;
  logic [PW-1:0] address, address_next;
  logic          map, map_next;

  mapper_banked #(.PADDR_W(PW), .NUM_SETS(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .ready             (ready),
    .sync              (sync),
    .data_i            (data_i),
    .data_o            (data_o),
    .core_address_next (core_address_next),
    .active_set        (active_set),
    .load_set          (load_set),
    .ext_irq           (ext_irq),
    .ext_nmi           (ext_nmi),
    .cpu_irq           (cpu_irq),
    .cpu_nmi           (cpu_nmi),
    .hv_we             (hv_we),
    .hv_set            (hv_set),
    .hv_sel            (hv_sel),
    .hv_wdata          (hv_wdata),
    .hv_rdata          (hv_rdata),
    .map_busy          (map_busy),
    .address           (address),
    .address_next      (address_next),
    .map               (map),
    .map_next          (map_next)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: registers per (set, half), pending MAP loads as a queue.
  bit [7:0] m_lo8 [2][2];
  bit [3:0] m_hi4 [2][2];
  bit [3:0] m_en  [2][2];
  bit [7:0] m_mb  [2][2];
  int       mq[$];
  bit       m_ie, m_pend, m_prev, m_map;
  longint   m_addr;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int s = 0; s < 2; s++)
      for (int h = 0; h < 2; h++) begin
        m_lo8[s][h] = 0; m_hi4[s][h] = 0;
        m_en[s][h] = 0;  m_mb[s][h] = 0;
      end
    mq.delete();
    m_ie = 1; m_pend = 0; m_prev = 0; m_map = 0; m_addr = 0;
  endtask

  task automatic m_wr(int s, int sel, bit [7:0] d);
    case (sel)
      0: begin m_en[s][1] = d[7:4]; m_hi4[s][1] = d[3:0]; end
      1: m_lo8[s][1] = d;
      2: begin m_en[s][0] = d[7:4]; m_hi4[s][0] = d[3:0]; end
      3: m_lo8[s][0] = d;
      4: m_mb[s][0] = d;
      5: m_mb[s][1] = d;
      default: ;
    endcase
  endtask

  function automatic bit [7:0] m_rd(int s, int sel);
    case (sel)
      0: return {m_en[s][1], m_hi4[s][1]};
      1: return m_lo8[s][1];
      2: return {m_en[s][0], m_hi4[s][0]};
      3: return m_lo8[s][0];
      4: return m_mb[s][0];
      5: return m_mb[s][1];
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit m_hit(bit [15:0] a, int s);
    return m_en[s][a[15]][a[14:13]];
  endfunction

  function automatic longint m_phys(bit [15:0] a, int s);
    longint o;
    int h = a[15];
    if (!m_hit(a, s)) return longint'(a);
    o = (longint'(m_mb[s][h]) << 12) + (longint'(m_hi4[s][h]) << 8)
      + longint'(m_lo8[s][h]);
    return (o * 256 + longint'(a)) & PMASK;
  endfunction

  // One clock: check combinational outputs, advance model, check registers.
  task automatic step();
    bit busy, em, ie_n, pend_n;
    longint ea;
    int sel = -1;
    #1;
    busy = (mq.size() != 0) || (ready && sync && data_i == 8'h5C);
    chk("map_busy", map_busy, busy);
    chk("cpu_irq", cpu_irq, ext_irq & m_ie);
    chk("cpu_nmi", cpu_nmi, m_ie & (ext_nmi | m_pend));
    chk("hv_rdata", hv_rdata, m_rd(hv_set, hv_sel));
    if (ready) begin
      ea = m_phys(core_address_next, active_set);
      em = m_hit(core_address_next, active_set);
    end else begin
      ea = m_addr;
      em = m_map;
    end
    chk("address_next", address_next, ea);
    chk("map_next", map_next, em);
    if (ready) begin
      ie_n = m_ie;
      pend_n = m_pend;
      if (mq.size() != 0) begin
        sel = mq.pop_front();
        m_wr(load_set, sel, data_o);
      end else if (sync && data_i == 8'h5C) begin
        mq = {3, 2, 1, 0};
      end
      if (hv_we && !busy) m_wr(hv_set, hv_sel, hv_wdata);
      if (sync && data_i == 8'hEA) ie_n = 1;
      if (sel == 3) ie_n = 0;
      if (m_ie) pend_n = 0;
      else if (ext_nmi && !m_prev) pend_n = 1;
      m_prev = ext_nmi;
      m_ie = ie_n;
      m_pend = pend_n;
      m_addr = ea;
      m_map = em;
    end
    @(posedge clk);
    #1;
    chk("address", address, m_addr);
    chk("map", map, m_map);
  endtask

  task automatic do_opc(bit [7:0] op);
    data_i = op; sync = 1; ready = 1;
    step();
    data_i = 8'h00; sync = 0;
  endtask

  task automatic do_load(bit [7:0] v);
    data_o = v; ready = 1;
    step();
  endtask

  task automatic hv_write(bit s, bit [2:0] sel, bit [7:0] d);
    hv_we = 1; hv_set = s; hv_sel = sel; hv_wdata = d; ready = 1;
    step();
    hv_we = 0;
  endtask

  initial begin
    m_reset();
    #12;
    chk("reset_address", address, 0);
    chk("reset_map", map, 0);
    chk("reset_busy", map_busy, 0);
    reset = 1;
    @(posedge clk); #1;

    // MAP A=40 X=A1 Y=00 Z=00 into set 0, then EOM
    load_set = 0; active_set = 0;
    do_opc(8'h5C);
    do_load(8'h40); do_load(8'hA1); do_load(8'h00); do_load(8'h00);
    do_opc(8'hEA);
    core_address_next = 16'h8123; step();
    chk("t1_high_half", address, 28'h0008123);
    chk("t1_high_map", map, 0);
    core_address_next = 16'h6123; step();
    chk("t1_region3", address, 28'h001A123);
    chk("t1_region3_map", map, 1);
    core_address_next = 16'h4123; step();
    chk("t1_region2_off", address, 28'h0004123);

    // ready held low for three cycles in LD_X
    hv_set = 0; hv_sel = 3'd2;
    do_opc(8'h5C);
    do_load(8'h12);
    data_o = 8'h3C; ready = 0;
    for (int i = 0; i < 3; i++) begin
      core_address_next = 16'(16'h2000 + i);
      step();
      chk("t2_stall_busy", map_busy, 1);
      chk("t2_stall_x", hv_rdata, 8'hA1);
    end
    do_load(8'h5F);
    chk("t2_x_loaded", hv_rdata, 8'h5F);
    do_load(8'h00); do_load(8'h00);
    do_opc(8'hEA);

    // NMI deferred across the MAP..EOM window, IRQ masked
    ext_irq = 1;
    do_opc(8'h5C);
    do_load(8'h00);
    chk("t4_irq_masked", cpu_irq, 0);
    ext_nmi = 1; do_load(8'h00);
    chk("t4_nmi_held", cpu_nmi, 0);
    ext_nmi = 0; do_load(8'h00); do_load(8'h00);
    chk("t4_nmi_still_held", cpu_nmi, 0);
    do_opc(8'hEA);
    chk("t4_nmi_release", cpu_nmi, 1);
    chk("t4_irq_release", cpu_irq, 1);
    step();
    chk("t4_nmi_pulse_end", cpu_nmi, 0);
    ext_irq = 0;

    // hv write during LD_Y is dropped, in IDLE it is accepted
    do_opc(8'h5C);
    do_load(8'h00); do_load(8'h00);
    hv_we = 1; hv_set = 1; hv_sel = 3'd3; hv_wdata = 8'h55;
    do_load(8'h00);
    hv_we = 0;
    chk("t5_dropped", hv_rdata, 8'h00);
    do_load(8'h00);
    hv_write(1, 3'd3, 8'h55);
    hv_write(1, 3'd2, 8'h10);
    chk("t5_accepted", hv_rdata, 8'h10);
    active_set = 1; core_address_next = 16'h0123; step();
    chk("t5_set1_xlate", address, 28'h0005623);

    // 28-bit wrap through the MB bits
    hv_write(0, 3'd4, 8'hFF);
    hv_write(0, 3'd3, 8'hFF);
    hv_write(0, 3'd2, 8'h1F);
    active_set = 0; core_address_next = 16'h0200; step();
    chk("t3_wrap", address, 28'h0000100);

    // reset asserted while in LD_Y
    do_opc(8'h5C);
    do_load(8'h77); do_load(8'hF3);
    ext_irq = 1; hv_set = 0; hv_sel = 3'd3;
    reset = 0;
    #1;
    m_reset();
    chk("t6_busy", map_busy, 0);
    chk("t6_int_en", cpu_irq, 1);
    chk("t6_offset", hv_rdata, 8'h00);
    chk("t6_address", address, 0);
    chk("t6_map", map, 0);
    #1 reset = 1;
    ext_irq = 0;

    for (int i = 0; i < 600; i++) begin
      int k = $urandom_range(0, 3);
      ready = ($urandom_range(0, 3) != 0);
      sync = $urandom_range(0, 1);
      data_i = (k == 0) ? 8'h5C : (k == 1) ? 8'hEA : 8'($urandom);
      data_o = 8'($urandom);
      core_address_next = 16'($urandom);
      active_set = 1'($urandom);
      load_set = 1'($urandom);
      hv_we = ($urandom_range(0, 2) == 0);
      hv_set = 1'($urandom);
      hv_sel = 3'($urandom);
      hv_wdata = 8'($urandom);
      ext_irq = 1'($urandom);
      if ($urandom_range(0, 3) == 0) ext_nmi = ~ext_nmi;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
